// File: rtl/ptp_irq_ctrl_pkg.sv
// Shared definitions for the xge-ptpv2 interrupt controller.
//   OFS_*        : register word offsets from INT_BASE_ADDR
//   irq_state_e  : combined-interrupt output FSM encoding
package ptp_irq_ctrl_pkg;

    localparam logic [31:0] OFS_STATUS  = 32'd0;
    localparam logic [31:0] OFS_MASK    = 32'd1;
    localparam logic [31:0] OFS_MODE    = 32'd2;
    localparam logic [31:0] OFS_RAW     = 32'd3;
    localparam logic [31:0] OFS_FORCE   = 32'd4;
    localparam logic [31:0] OFS_HOLDOFF = 32'd5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAssert = 2'd1,
        StHold   = 2'd2
    } irq_state_e;

endpackage

// File: rtl/ptp_irq_ctrl_if.sv
// bus2ip register bus bundle.
//   bus2ip_addr  : 32-bit word address
//   bus2ip_data  : write data
//   bus2ip_rd_ce : read strobe, active high
//   bus2ip_wr_ce : write strobe, active high, one write per high cycle
//   ip2bus_data  : read data, combinational from the slave
interface ptp_irq_ctrl_if;

    logic [31:0] bus2ip_addr;
    logic [31:0] bus2ip_data;
    logic        bus2ip_rd_ce;
    logic        bus2ip_wr_ce;
    logic [31:0] ip2bus_data;

    modport master (
        output bus2ip_addr,
        output bus2ip_data,
        output bus2ip_rd_ce,
        output bus2ip_wr_ce,
        input  ip2bus_data
    );

    modport slave (
        input  bus2ip_addr,
        input  bus2ip_data,
        input  bus2ip_rd_ce,
        input  bus2ip_wr_ce,
        output ip2bus_data
    );

endinterface

// File: rtl/ptp_irq_ctrl_sync_edge.sv
// Single-bit synchroniser with rising-edge detect.
//   bus2ip_clk, bus2ip_rst_n : clock, asynchronous active-low reset
//   src_i                    : raw asynchronous input
//   sync_o                   : synchronised level (SYNC_STAGES flops deep)
//   rise_o                   : one-cycle pulse when sync_o goes 0 -> 1
module ptp_irq_ctrl_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic bus2ip_clk,
    input  logic bus2ip_rst_n,
    input  logic src_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ptp_irq_ctrl.sv
// Parametrised interrupt controller for the xge-ptpv2 core.
//   bus2ip_clk, bus2ip_rst_n : clock, asynchronous active-low reset
//   bus                      : bus2ip register bus (slave side)
//   int_src_i                : raw interrupt sources, asynchronous
//   int_pend_o               : registered STATUS & MASK
//   int_ptp_o                : combined interrupt with hold-off coalescing
module ptp_irq_ctrl
    import ptp_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 8,
    parameter logic [31:0] INT_BASE_ADDR = 32'h300,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned HOLDOFF_W     = 16
) (
    input  logic               bus2ip_clk,
    input  logic               bus2ip_rst_n,
    ptp_irq_ctrl_if.slave      bus,
    input  logic [NUM_SRC-1:0] int_src_i,
    output logic [NUM_SRC-1:0] int_pend_o,
    output logic               int_ptp_o
);

    logic [NUM_SRC-1:0]   src_sync, src_rise;
    logic [NUM_SRC-1:0]   status_q, status_d, mask_q, mode_q, pend_q;
    logic [NUM_SRC-1:0]   wdata, w1c, set;
    logic [HOLDOFF_W-1:0] holdoff_q, cnt_q, cnt_d;
    irq_state_e           state_q, state_d;
    logic                 int_ptp_q;
    logic [31:0]          ofs, rdata;
    logic                 wr_status, wr_mask, wr_mode, wr_force, wr_holdoff;
    logic                 unused_wdata;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        ptp_irq_ctrl_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .bus2ip_clk   (bus2ip_clk),
            .bus2ip_rst_n (bus2ip_rst_n),
            .src_i        (int_src_i[i]),
            .sync_o       (src_sync[i]),
            .rise_o       (src_rise[i])
        );
    end

    // Modular subtraction keeps the decode a full 32-bit compare: ofs == k only for base + k.
    assign ofs        = bus.bus2ip_addr - INT_BASE_ADDR;
    assign wdata      = bus.bus2ip_data[NUM_SRC-1:0];
    assign wr_status  = bus.bus2ip_wr_ce && (ofs == OFS_STATUS);
    assign wr_mask    = bus.bus2ip_wr_ce && (ofs == OFS_MASK);
    assign wr_mode    = bus.bus2ip_wr_ce && (ofs == OFS_MODE);
    assign wr_force   = bus.bus2ip_wr_ce && (ofs == OFS_FORCE);
    assign wr_holdoff = bus.bus2ip_wr_ce && (ofs == OFS_HOLDOFF);
    assign unused_wdata = ^bus.bus2ip_data;

    // Set is OR-ed in after the clear, so a same-cycle set beats W1C.
    assign w1c      = wr_status ? wdata : '0;
    assign set      = (mode_q & src_sync) | (~mode_q & src_rise) | (wr_force ? wdata : '0);
    assign status_d = (status_q & ~w1c) | set;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|pend_q) state_d = StAssert;
            end
            StAssert: begin
                if (~|pend_q) begin
                    if (holdoff_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHold;
                        cnt_d   = holdoff_q;
                    end
                end
            end
            StHold: begin
                cnt_d = cnt_q - HOLDOFF_W'(1);
                // Bits that arrived during hold-off fire on the cycle IDLE would be entered.
                if (cnt_q == HOLDOFF_W'(1)) state_d = (|pend_q) ? StAssert : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            status_q  <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            holdoff_q <= '0;
            pend_q    <= '0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            int_ptp_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            pend_q    <= status_q & mask_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_ptp_q <= (state_d == StAssert);
            if (wr_mask)    mask_q    <= wdata;
            if (wr_mode)    mode_q    <= wdata;
            if (wr_holdoff) holdoff_q <= bus.bus2ip_data[HOLDOFF_W-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.bus2ip_rd_ce) begin
            unique case (ofs)
                OFS_STATUS:  rdata[NUM_SRC-1:0]   = status_q;
                OFS_MASK:    rdata[NUM_SRC-1:0]   = mask_q;
                OFS_MODE:    rdata[NUM_SRC-1:0]   = mode_q;
                OFS_RAW:     rdata[NUM_SRC-1:0]   = src_sync;
                OFS_HOLDOFF: rdata[HOLDOFF_W-1:0] = holdoff_q;
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.ip2bus_data = rdata;
    assign int_pend_o      = pend_q;
    assign int_ptp_o       = int_ptp_q;

endmodule
